// File: rtl/bp_table_ctrl.sv
// Branch-history table of 2-bit saturating counters with global history,
// clearing sweep after reset/flush, combinational lookup and mispredict counter.
module bp_table_ctrl #(
    parameter int unsigned BP_ADDR_BITS = 12,
    parameter int unsigned BH_BITS      = 9,
    parameter logic [1:0]  INIT_CTR     = 2'b01
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flushReq_i,
    input  logic [31:0]             lkPC_i,
    output logic [BP_ADDR_BITS-1:0] lkIndex_o,
    output logic                    lkPredict_o,
    output logic                    lkValid_o,
    input  logic                    updValid_i,
    input  logic [BP_ADDR_BITS-1:0] updIndex_i,
    input  logic                    updTaken_i,
    input  logic                    updPredicted_i,
    output logic                    busy_o,
    output logic [BH_BITS-1:0]      ghr_o,
    output logic [31:0]             mispredCnt_o
);

    localparam int unsigned DEPTH     = 1 << BP_ADDR_BITS;
    localparam int unsigned GHR_SHIFT = BP_ADDR_BITS - BH_BITS;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BP_ADDR_BITS-1:0] r_sidx;
    logic [BP_ADDR_BITS-1:0] w_sidx_nxt;
    logic [BH_BITS-1:0]      r_ghr;
    logic [BH_BITS-1:0]      w_ghr_nxt;
    logic [31:0]             r_mispred_cnt;
    logic [31:0]             w_mispred_nxt;
    logic [1:0]              r_table [DEPTH];

    logic                    w_we;
    logic [BP_ADDR_BITS-1:0] w_waddr;
    logic [1:0]              w_wdata;
    logic [1:0]              w_upd_ctr;
    logic [BP_ADDR_BITS-1:0] w_ghr_ext;
    logic                    w_busy;
    logic                    w_unused_pc;

    assign w_busy      = (r_state == ST_CLEAR);
    assign w_upd_ctr   = r_table[updIndex_i];
    assign w_ghr_ext   = BP_ADDR_BITS'(r_ghr) << GHR_SHIFT;
    assign w_unused_pc = ^{lkPC_i[31:BP_ADDR_BITS+1], lkPC_i[0]};

    // Lookup reads the pre-write table contents, so a same-cycle write is seen next cycle.
    assign lkIndex_o    = lkPC_i[BP_ADDR_BITS:1] ^ w_ghr_ext;
    assign lkPredict_o  = r_table[lkIndex_o][1] & ~w_busy;
    assign lkValid_o    = ~w_busy;
    assign busy_o       = w_busy;
    assign ghr_o        = r_ghr;
    assign mispredCnt_o = r_mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= ST_CLEAR;
            r_sidx        <= '0;
            r_ghr         <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sidx        <= w_sidx_nxt;
            r_ghr         <= w_ghr_nxt;
            r_mispred_cnt <= w_mispred_nxt;
        end
    end

    // Single write port; reset suppresses any write in its cycle.
    always_ff @(posedge clk_i) begin
        if (w_we && !reset_i) begin
            r_table[w_waddr] <= w_wdata;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sidx_nxt    = r_sidx;
        w_ghr_nxt     = r_ghr;
        w_mispred_nxt = r_mispred_cnt;
        w_we          = 1'b0;
        w_waddr       = r_sidx;
        w_wdata       = INIT_CTR;

        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
                if (flushReq_i) begin
                    w_sidx_nxt = '0;
                end else begin
                    w_sidx_nxt = r_sidx + BP_ADDR_BITS'(1);
                    if (r_sidx == '1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (flushReq_i) begin
                    w_state_nxt = ST_CLEAR;
                    w_sidx_nxt  = '0;
                    w_ghr_nxt   = '0;
                end else if (updValid_i) begin
                    w_we    = 1'b1;
                    w_waddr = updIndex_i;
                    if (updTaken_i) begin
                        w_wdata = (w_upd_ctr == 2'b11) ? 2'b11 : w_upd_ctr + 2'b01;
                    end else begin
                        w_wdata = (w_upd_ctr == 2'b00) ? 2'b00 : w_upd_ctr - 2'b01;
                    end
                    w_ghr_nxt = (r_ghr >> 1) | (BH_BITS'(updTaken_i) << (BH_BITS - 1));
                    if ((updTaken_i != updPredicted_i) && (r_mispred_cnt != '1)) begin
                        w_mispred_nxt = r_mispred_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_sidx_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Randomized and directed bench for bp_table_ctrl against a behavioural predictor model.
module tb_bp_table_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned HW = 2;
    localparam int unsigned N  = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          flushReq_i;
    logic [31:0]   lkPC_i;
    logic [AW-1:0] lkIndex_o;
    logic          lkPredict_o;
    logic          lkValid_o;
    logic          updValid_i;
    logic [AW-1:0] updIndex_i;
    logic          updTaken_i;
    logic          updPredicted_i;
    logic          busy_o;
    logic [HW-1:0] ghr_o;
    logic [31:0]   mispredCnt_o;

    bp_table_ctrl #(.BP_ADDR_BITS(AW), .BH_BITS(HW), .INIT_CTR(2'b01)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flushReq_i(flushReq_i), .lkPC_i(lkPC_i),
        .lkIndex_o(lkIndex_o), .lkPredict_o(lkPredict_o), .lkValid_o(lkValid_o),
        .updValid_i(updValid_i), .updIndex_i(updIndex_i), .updTaken_i(updTaken_i),
        .updPredicted_i(updPredicted_i), .busy_o(busy_o), .ghr_o(ghr_o),
        .mispredCnt_o(mispredCnt_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_checks = 0;
    int     n_errors = 0;
    bit     chk_en   = 0;

    // Model: counters as ints, busy as cycles left in the sweep, history as int.
    int     m_ctr [N];
    int     m_busy_left = 0;
    int     m_ghr = 0;
    longint m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_sweep();
        m_busy_left = N;
        for (int i = 0; i < int'(N); i++) m_ctr[i] = 1;
    endtask

    always @(posedge clk_i) begin
        if (reset_i) begin
            start_sweep();
            m_ghr = 0;
            m_cnt = 0;
        end else if (m_busy_left > 0) begin
            if (flushReq_i) m_busy_left = N;
            else m_busy_left = m_busy_left - 1;
        end else if (flushReq_i) begin
            start_sweep();
            m_ghr = 0;
        end else if (updValid_i) begin
            if (updTaken_i) m_ctr[updIndex_i] = (m_ctr[updIndex_i] >= 3) ? 3 : m_ctr[updIndex_i] + 1;
            else            m_ctr[updIndex_i] = (m_ctr[updIndex_i] <= 0) ? 0 : m_ctr[updIndex_i] - 1;
            m_ghr = (m_ghr / 2) + (updTaken_i ? 2 : 0);
            if (updTaken_i != updPredicted_i && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            int  idx;
            bit  busy;
            busy = (m_busy_left > 0);
            idx  = ((lkPC_i >> 1) % N) ^ ((m_ghr * 4) % N);
            chk("busy", 32'(busy_o), 32'(busy));
            chk("valid", 32'(lkValid_o), 32'(!busy));
            chk("lkindex", 32'(lkIndex_o), 32'(idx));
            chk("predict", 32'(lkPredict_o), (busy || m_ctr[idx] < 2) ? 32'd0 : 32'd1);
            chk("ghr", 32'(ghr_o), 32'(m_ghr));
            chk("mispred", mispredCnt_o, 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input int idx, input bit taken, input bit pred);
        updValid_i     = 1'b1;
        updIndex_i     = AW'(idx);
        updTaken_i     = taken;
        updPredicted_i = pred;
        tick();
        updValid_i     = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        int     n;
        longint cnt_before;
        reset_i = 1'b1; flushReq_i = 1'b0; lkPC_i = '0;
        updValid_i = 1'b0; updIndex_i = '0; updTaken_i = 1'b0; updPredicted_i = 1'b0;
        tick();
        chk_en  = 1;
        reset_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_valid", 32'(lkValid_o), 32'd0);
        chk("rst_ghr", 32'(ghr_o), 32'd0);
        chk("rst_cnt", mispredCnt_o, 32'd0);
        count_busy(n);
        chk("sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < int'(N); i++) begin
            lkPC_i = 32'(i * 2);
            tick();
            chk("init_pred", 32'(lkPredict_o), 32'd0);
        end

        // Saturation on entry 5, history drained back to zero via entry 0.
        repeat (3) upd(5, 1'b1, 1'b0);
        upd(0, 1'b0, 1'b0);
        upd(0, 1'b0, 1'b0);
        lkPC_i = 32'hA;
        #1;
        chk("sat_idx", 32'(lkIndex_o), 32'd5);
        chk("sat_pred_hi", 32'(lkPredict_o), 32'd1);
        repeat (4) upd(5, 1'b0, 1'b1);
        upd(5, 1'b1, 1'b0);
        upd(0, 1'b0, 1'b0);
        upd(0, 1'b0, 1'b0);
        chk("sat_floor", 32'(lkPredict_o), 32'd0);

        // History and index hashing.
        upd(1, 1'b1, 1'b1);
        upd(1, 1'b1, 1'b1);
        chk("ghr_11", 32'(ghr_o), 32'd3);
        lkPC_i = 32'h0000_0006;
        #1;
        chk("idx_hash", 32'(lkIndex_o), 32'hF);

        // Flush with a concurrent update while entry 5 is strongly taken.
        upd(5, 1'b1, 1'b1);
        upd(5, 1'b1, 1'b1);
        upd(0, 1'b0, 1'b0);
        upd(0, 1'b1, 1'b1);
        chk("ghr_10", 32'(ghr_o), 32'd2);
        cnt_before = m_cnt;
        flushReq_i = 1'b1;
        upd(5, 1'b0, 1'b1);
        flushReq_i = 1'b0;
        count_busy(n);
        chk("flush_len", 32'(n), 32'd16);
        chk("flush_ghr", 32'(ghr_o), 32'd0);
        chk("flush_cnt", mispredCnt_o, 32'(cnt_before));
        lkPC_i = 32'hA;
        upd(5, 1'b0, 1'b0);
        chk("flush_ctr5", 32'(lkPredict_o), 32'd0);

        // Flush during the sweep, reset during the sweep.
        pulse_reset();
        repeat (7) tick();
        flushReq_i = 1'b1;
        tick();
        flushReq_i = 1'b0;
        count_busy(n);
        chk("flush_in_sweep", 32'(n), 32'd16);
        pulse_reset();
        repeat (3) tick();
        pulse_reset();
        count_busy(n);
        chk("reset_in_sweep", 32'(n), 32'd16);

        // Mispredict counting, including one dropped during the sweep.
        pulse_reset();
        upd(3, 1'b1, 1'b0);
        chk("clear_mispred", mispredCnt_o, 32'd0);
        count_busy(n);
        chk("sweep_rest", 32'(n), 32'd15);
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 1) upd(i, 1'b1, 1'b1);
            else            upd(i, 1'b0, 1'b1);
        end
        chk("mispred_5", mispredCnt_o, 32'd5);

        force dut.r_mispred_cnt = 32'hFFFF_FFFF;
        m_cnt = 64'hFFFF_FFFF;
        tick();
        release dut.r_mispred_cnt;
        upd(2, 1'b1, 1'b0);
        chk("mispred_sat", mispredCnt_o, 32'hFFFF_FFFF);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            lkPC_i         = $urandom;
            updValid_i     = 1'($urandom_range(0, 1));
            updIndex_i     = AW'($urandom_range(0, N - 1));
            updTaken_i     = 1'($urandom_range(0, 1));
            updPredicted_i = 1'($urandom_range(0, 1));
            flushReq_i     = ($urandom_range(0, 59) == 0);
            reset_i        = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset_i = 1'b0; flushReq_i = 1'b0; updValid_i = 1'b0;
        tick();
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
